// File: rtl/broadcast_stream_unit_pkg.sv
// Shared types and default parameters for the broadcast stream unit.
// Optional feature macro used elsewhere: BCAST_STALL_CNT_EN.
package broadcast_stream_unit_pkg;

   localparam int unsigned DATA_W_DEF   = 8;
   localparam int unsigned LANES_DEF    = 8;
   localparam int unsigned WR_LANES_DEF = 8;
   localparam int unsigned DEPTH_DEF    = 512;

   typedef enum logic [1:0] {
      IDLE,
      CFG,
      LOAD,
      STREAM
   } bcast_state_t;

endpackage

// File: rtl/broadcast_stream_unit_if.sv
// Config / SRAM write / output stream bundle for broadcast_stream_unit.
// stall_cnt_o exists only when BCAST_STALL_CNT_EN is defined.
interface broadcast_stream_unit_if
   import broadcast_stream_unit_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned LANES    = LANES_DEF,
   parameter int unsigned WR_LANES = WR_LANES_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
);
   localparam int unsigned ADDR_W = $clog2(DEPTH);

   logic                         cfg_valid_i;
   logic                         cfg_ready_o;
   logic [ADDR_W:0]              num_elem_i;
   logic [31:0]                  beats_i;
   logic                         wr_valid_i;
   logic                         wr_ready_o;
   logic [WR_LANES*DATA_W-1:0]   wr_data_i;
   logic                         out_valid_o;
   logic                         out_ready_i;
   logic [LANES*DATA_W-1:0]      out_data_o;
   logic                         out_last_o;
   logic                         flush_i;
   logic                         busy_o;
   logic                         err_o;
`ifdef BCAST_STALL_CNT_EN
   logic [31:0]                  stall_cnt_o;
`endif

   // Upstream / consumer side
   modport master (
      output cfg_valid_i, num_elem_i, beats_i, wr_valid_i, wr_data_i, out_ready_i, flush_i,
      input  cfg_ready_o, wr_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, err_o
`ifdef BCAST_STALL_CNT_EN
      , input stall_cnt_o
`endif
   );

   // Broadcast unit side
   modport slave (
      input  cfg_valid_i, num_elem_i, beats_i, wr_valid_i, wr_data_i, out_ready_i, flush_i,
      output cfg_ready_o, wr_ready_o, out_valid_o, out_data_o, out_last_o, busy_o, err_o
`ifdef BCAST_STALL_CNT_EN
      , output stall_cnt_o
`endif
   );

endinterface

// File: rtl/broadcast_stream_unit_lane_idx.sv
// Per-lane modular cache index: loads an initial value, advances by step mod N.
module broadcast_stream_unit_lane_idx #(
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              init,
   input  logic [ADDR_W-1:0] init_val,
   input  logic              adv,
   input  logic [ADDR_W:0]   step,
   input  logic [ADDR_W:0]   num,
   output logic [ADDR_W-1:0] idx,
   output logic [ADDR_W-1:0] nxt
);

   logic [ADDR_W:0] sum;
   logic [ADDR_W:0] wrapped;

   // idx < N and step < N, so a single conditional subtract keeps the result in range
   always_comb begin
      sum     = {1'b0, idx} + step;
      wrapped = sum - num;
      nxt     = (sum >= num) ? wrapped[ADDR_W-1:0] : sum[ADDR_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         idx <= '0;
      end else if (init) begin
         idx <= init_val;
      end else if (adv) begin
         idx <= nxt;
      end
   end

endmodule

// File: rtl/broadcast_stream_unit.sv
// Loads an N-element vector into a local cache and streams LANES-wide beats wrapping mod N.
// Define BCAST_STALL_CNT_EN to add the stall_cnt_o back-pressure counter.
module broadcast_stream_unit
   import broadcast_stream_unit_pkg::*;
#(
   parameter int unsigned DATA_W   = DATA_W_DEF,
   parameter int unsigned LANES    = LANES_DEF,
   parameter int unsigned WR_LANES = WR_LANES_DEF,
   parameter int unsigned DEPTH    = DEPTH_DEF
) (
   input logic                   clk,
   input logic                   rst,
   broadcast_stream_unit_if.slave bus
);

   localparam int unsigned ADDR_W = $clog2(DEPTH);
   localparam int unsigned FP_W   = ADDR_W + 2;
   localparam logic [ADDR_W:0] DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LANES_V  = (ADDR_W+1)'(LANES);
   localparam logic [FP_W-1:0] WR_LANES_V = FP_W'(WR_LANES);

   bcast_state_t            state;
   logic [ADDR_W:0]         n_r;
   logic [ADDR_W:0]         step_r;
   logic [31:0]             beats_r;
   logic [31:0]             beat_cnt;
   logic [FP_W-1:0]         fill_ptr;
   logic                    out_valid;
   logic                    out_last;
   logic                    err;
   logic [LANES*DATA_W-1:0] out_data;

   logic [DATA_W-1:0]       cache [DEPTH];
   logic [ADDR_W-1:0]       idx      [LANES];
   logic [ADDR_W-1:0]       nxt      [LANES];
   logic [ADDR_W-1:0]       init_val [LANES];
   logic                    wr_en    [WR_LANES];
   logic [ADDR_W-1:0]       wr_addr  [WR_LANES];
   logic [LANES*DATA_W-1:0] cur_word;
   logic [LANES*DATA_W-1:0] nxt_word;

   logic n_legal;
   logic cfg_go;
   logic stream_accept;
   logic load_write;

   assign n_legal       = (bus.num_elem_i != '0) && (bus.num_elem_i <= DEPTH_V);
   assign cfg_go        = (state == IDLE) && bus.cfg_valid_i && !bus.flush_i && n_legal;
   assign stream_accept = (state == STREAM) && out_valid && bus.out_ready_i && !bus.flush_i;
   assign load_write    = (state == LOAD) && bus.wr_valid_i && !bus.flush_i;

   // Lane m starts at m mod N, built as a running counter that wraps at N
   always_comb begin
      logic [ADDR_W:0] run;
      run = '0;
      for (int unsigned m = 0; m < LANES; m++) begin
         init_val[m] = run[ADDR_W-1:0];
         run = run + 1'b1;
         if (run == n_r) run = '0;
      end
   end

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      broadcast_stream_unit_lane_idx #(.ADDR_W(ADDR_W)) u_lane_idx (
         .clk      (clk),
         .rst      (rst),
         .init     (state == CFG),
         .init_val (init_val[g]),
         .adv      (stream_accept),
         .step     (step_r),
         .num      (n_r),
         .idx      (idx[g]),
         .nxt      (nxt[g])
      );
   end

   always_comb begin
      cur_word = '0;
      nxt_word = '0;
      for (int unsigned m = 0; m < LANES; m++) begin
         cur_word[m*DATA_W +: DATA_W] = cache[idx[m]];
         nxt_word[m*DATA_W +: DATA_W] = cache[nxt[m]];
      end
   end

   always_comb begin
      logic [FP_W-1:0] p;
      for (int unsigned k = 0; k < WR_LANES; k++) begin
         p          = fill_ptr + FP_W'(k);
         wr_en[k]   = p < FP_W'(n_r);
         wr_addr[k] = p[ADDR_W-1:0];
      end
   end

   always_ff @(posedge clk) begin
      if (load_write) begin
         for (int unsigned k = 0; k < WR_LANES; k++) begin
            if (wr_en[k]) cache[wr_addr[k]] <= bus.wr_data_i[k*DATA_W +: DATA_W];
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         n_r      <= '0;
         step_r   <= '0;
         beats_r  <= '0;
         beat_cnt <= '0;
         fill_ptr <= '0;
         out_valid <= 1'b0;
         out_last <= 1'b0;
         out_data <= '0;
         err      <= 1'b0;
      end else begin
         err <= 1'b0;
         if (bus.flush_i) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end else begin
            case (state)
               IDLE: begin
                  if (bus.cfg_valid_i) begin
                     if (n_legal) begin
                        n_r     <= bus.num_elem_i;
                        beats_r <= bus.beats_i;
                        step_r  <= LANES_V;
                        state   <= CFG;
                     end else begin
                        err <= 1'b1;
                     end
                  end
               end
               CFG: begin
                  if (step_r >= n_r) begin
                     step_r <= step_r - n_r;
                  end else begin
                     fill_ptr <= '0;
                     state    <= LOAD;
                  end
               end
               LOAD: begin
                  if (bus.wr_valid_i) begin
                     fill_ptr <= fill_ptr + WR_LANES_V;
                     if (fill_ptr + WR_LANES_V >= FP_W'(n_r)) begin
                        beat_cnt <= '0;
                        state    <= STREAM;
                     end
                  end
               end
               STREAM: begin
                  if (!out_valid) begin
                     out_valid <= 1'b1;
                     out_data  <= cur_word;
                     out_last  <= (beats_r == 32'd1);
                  end else if (bus.out_ready_i) begin
                     beat_cnt <= beat_cnt + 32'd1;
                     if ((beats_r != '0) && (beat_cnt + 32'd1 == beats_r)) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                     end else begin
                        // Next beat is fetched with the advanced indices so accepts can be back-to-back
                        out_data <= nxt_word;
                        out_last <= (beats_r != '0) && (beat_cnt + 32'd2 == beats_r);
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

`ifdef BCAST_STALL_CNT_EN
   logic [31:0] stall_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt <= '0;
      end else if (cfg_go) begin
         stall_cnt <= '0;
      end else if ((state == STREAM) && out_valid && !bus.out_ready_i && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + 32'd1;
      end
   end

   assign bus.stall_cnt_o = stall_cnt;
`endif

   assign bus.cfg_ready_o = (state == IDLE);
   assign bus.wr_ready_o  = (state == LOAD);
   assign bus.busy_o      = (state != IDLE);
   assign bus.out_valid_o = out_valid;
   assign bus.out_last_o  = out_last;
   assign bus.out_data_o  = out_data;
   assign bus.err_o       = err;

endmodule

// File: tb/tb_broadcast_stream_unit.sv
// Scoreboard bench for broadcast_stream_unit: random vectors, beat i lane m = vec[(i*LANES+m) mod N].
module tb_broadcast_stream_unit;

   localparam int DATA_W   = 8;
   localparam int LANES    = 8;
   localparam int WR_LANES = 8;
   localparam int DEPTH    = 512;
   localparam int ADDR_W   = $clog2(DEPTH);
   localparam int BW       = LANES * DATA_W;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   broadcast_stream_unit_if #(
      .DATA_W(DATA_W), .LANES(LANES), .WR_LANES(WR_LANES), .DEPTH(DEPTH)
   ) bus ();

   broadcast_stream_unit #(
      .DATA_W(DATA_W), .LANES(LANES), .WR_LANES(WR_LANES), .DEPTH(DEPTH)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [BW-1:0] data;
      logic          last;
   } beat_t;

   beat_t             sb[$];
   int                tests = 0;
   int                fails = 0;
   int                acc   = 0;
   logic [DATA_W-1:0] vec [DEPTH];

   function automatic void chk(string name, logic [BW-1:0] act, logic [BW-1:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Monitor: pops on each handshake, and checks the beat stays put while stalled
   logic [BW-1:0] held;
   logic          holding = 1'b0;
   beat_t         mon_e;

   always @(negedge clk) begin
      if (rst && bus.out_valid_o) begin
         if (holding) chk("hold_data", bus.out_data_o, held);
         if (bus.out_ready_i) begin
            if (sb.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_beat: got %0h expected no beat", bus.out_data_o);
            end else begin
               mon_e = sb.pop_front();
               chk("beat_data", bus.out_data_o, mon_e.data);
               chk("beat_last", BW'(bus.out_last_o), BW'(mon_e.last));
            end
            acc++;
            holding = 1'b0;
         end else begin
            holding = 1'b1;
            held    = bus.out_data_o;
         end
      end else begin
         holding = 1'b0;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic push_beats(int n, int count, bit finite);
      beat_t e;
      for (int b = 0; b < count; b++) begin
         for (int m = 0; m < LANES; m++) e.data[m*DATA_W +: DATA_W] = vec[(b*LANES + m) % n];
         e.last = finite && (b == count - 1);
         sb.push_back(e);
      end
   endtask

   task automatic do_cfg(int n, int beats);
      chk("cfg_ready_idle", BW'(bus.cfg_ready_o), BW'(1));
      bus.cfg_valid_i = 1'b1;
      bus.num_elem_i  = (ADDR_W+1)'(n);
      bus.beats_i     = 32'(beats);
      @(posedge clk); #1;
      bus.cfg_valid_i = 1'b0;
   endtask

   task automatic send_word(logic [WR_LANES*DATA_W-1:0] w);
      int t = 0;
      bus.wr_valid_i = 1'b1;
      bus.wr_data_i  = w;
      @(negedge clk);
      while (!bus.wr_ready_o && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (!bus.wr_ready_o) begin
         tests++;
         fails++;
         $display("FAIL wr_ready_timeout: got 0 expected 1");
      end
      @(posedge clk); #1;
      bus.wr_valid_i = 1'b0;
   endtask

   task automatic do_load(int n);
      logic [WR_LANES*DATA_W-1:0] w;
      int idx;
      for (int i = 0; i < n; i++) vec[i] = DATA_W'($urandom);
      for (int wd = 0; wd < (n + WR_LANES - 1) / WR_LANES; wd++) begin
         for (int k = 0; k < WR_LANES; k++) begin
            idx = wd * WR_LANES + k;
            w[k*DATA_W +: DATA_W] = (idx < n) ? vec[idx] : DATA_W'($urandom);
         end
         if ($urandom_range(0, 3) == 0) begin
            @(posedge clk); #1;
         end
         send_word(w);
      end
   endtask

   // mode 0: ready always high, 1: random ready, 2: 4-cycle stall on the second beat
   task automatic do_stream(int mode, int acc0);
      int t = 0;
      int stall_left = 4;
      while (t < 5000) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !bus.busy_o) break;
         case (mode)
            1: bus.out_ready_i = ($urandom_range(0, 3) != 0);
            2: begin
               if ((acc - acc0) == 1 && stall_left > 0) begin
                  bus.out_ready_i = 1'b0;
                  stall_left--;
               end else begin
                  bus.out_ready_i = 1'b1;
               end
            end
            default: bus.out_ready_i = 1'b1;
         endcase
         t++;
      end
      if (t >= 5000) begin
         tests++;
         fails++;
         $display("FAIL stream_timeout: got %0d beats left expected 0", sb.size());
         sb.delete();
      end
      bus.out_ready_i = 1'b1;
      chk("idle_valid", BW'(bus.out_valid_o), BW'(0));
      chk("idle_busy", BW'(bus.busy_o), BW'(0));
   endtask

   task automatic run_job(int n, int beats, int mode);
      int acc0 = acc;
      bus.out_ready_i = 1'b1;
      do_cfg(n, beats);
      do_load(n);
      push_beats(n, beats, 1'b1);
      do_stream(mode, acc0);
   endtask

   task automatic illegal_cfg(int n);
      bus.cfg_valid_i = 1'b1;
      bus.num_elem_i  = (ADDR_W+1)'(n);
      bus.beats_i     = 32'd2;
      @(posedge clk); #1;
      bus.cfg_valid_i = 1'b0;
      chk("err_pulse", BW'(bus.err_o), BW'(1));
      chk("err_busy", BW'(bus.busy_o), BW'(0));
      @(posedge clk); #1;
      chk("err_clear", BW'(bus.err_o), BW'(0));
      chk("err_busy2", BW'(bus.busy_o), BW'(0));
      chk("err_wr_ready", BW'(bus.wr_ready_o), BW'(0));
   endtask

   initial begin
      int acc0;
      int t;
      bus.cfg_valid_i = 1'b0;
      bus.num_elem_i  = '0;
      bus.beats_i     = '0;
      bus.wr_valid_i  = 1'b0;
      bus.wr_data_i   = '0;
      bus.out_ready_i = 1'b0;
      bus.flush_i     = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cfg_ready", BW'(bus.cfg_ready_o), BW'(1));
      chk("rst_busy", BW'(bus.busy_o), BW'(0));
      chk("rst_valid", BW'(bus.out_valid_o), BW'(0));
      chk("rst_wr_ready", BW'(bus.wr_ready_o), BW'(0));
      chk("rst_err", BW'(bus.err_o), BW'(0));
      chk("rst_last", BW'(bus.out_last_o), BW'(0));
      chk("rst_data", bus.out_data_o, '0);
      rst = 1'b1;
      @(posedge clk); #1;

      run_job(12, 3, 0);
      run_job(1, 2, 0);
      run_job(5, 4, 2);
`ifdef BCAST_STALL_CNT_EN
      chk("stall_cnt", BW'(bus.stall_cnt_o), BW'(4));
`endif
      run_job(20, 3, 0);
      run_job(8, 3, 1);
      run_job(7, 5, 1);

      illegal_cfg(0);
      illegal_cfg(DEPTH + 1);

      // cfg and flush together: flush wins
      bus.cfg_valid_i = 1'b1;
      bus.flush_i     = 1'b1;
      bus.num_elem_i  = (ADDR_W+1)'(4);
      bus.beats_i     = 32'd1;
      @(posedge clk); #1;
      bus.cfg_valid_i = 1'b0;
      bus.flush_i     = 1'b0;
      chk("cfg_flush_busy", BW'(bus.busy_o), BW'(0));

      // Endless job flushed after 5 beats
      acc0 = acc;
      bus.out_ready_i = 1'b1;
      do_cfg(9, 0);
      do_load(9);
      push_beats(9, 5, 1'b0);
      t = 0;
      while ((acc - acc0) < 5 && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      chk("flush_beats", BW'(acc - acc0), BW'(5));
      bus.out_ready_i = 1'b0;
      bus.flush_i     = 1'b1;
      @(posedge clk); #1;
      bus.flush_i = 1'b0;
      chk("flush_valid", BW'(bus.out_valid_o), BW'(0));
      chk("flush_busy", BW'(bus.busy_o), BW'(0));
      chk("flush_cfg_ready", BW'(bus.cfg_ready_o), BW'(1));
      chk("flush_sb_empty", BW'(sb.size()), BW'(0));
      sb.delete();
      bus.out_ready_i = 1'b1;

      for (int i = 0; i < 6; i++) run_job($urandom_range(1, 40), $urandom_range(1, 8), 1);
      run_job(DEPTH, 65, 1);

      // Asynchronous reset in the middle of a load
      do_cfg(20, 3);
      send_word('1);
      #3;
      rst = 1'b0;
      #1;
      chk("arst_busy", BW'(bus.busy_o), BW'(0));
      chk("arst_wr_ready", BW'(bus.wr_ready_o), BW'(0));
      chk("arst_cfg_ready", BW'(bus.cfg_ready_o), BW'(1));
      chk("arst_valid", BW'(bus.out_valid_o), BW'(0));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;

      run_job(12, 3, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
